// File: rtl/trace_arbiter.sv
// trace_arbiter: round-robin arbiter giving NUM_CORES trace requesters one-at-a-time access to a shared cache.
// Define TRACE_ARB_STATS_EN to build the per-core saturating hit/miss counters; otherwise they read as 0.
module trace_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CORES-1:0]       req,
    input  logic [NUM_CORES*32-1:0]    core_addr,
    output logic [NUM_CORES-1:0]       ack,
    output logic                       trace_ready,
    output logic [31:0]                mem_addr,
    input  logic                       updated,
    input  logic                       found_in_cache,
    output logic [2:0]                 grant_id,
    output logic                       busy,
    output logic [NUM_CORES*CNT_W-1:0] core_hit_count,
    output logic [NUM_CORES*CNT_W-1:0] core_miss_count
);
    localparam int IW = $clog2(NUM_CORES);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    logic [1:0] state;
    logic [2:0] last_grant, nxt_grant;
    logic [3:0] idx;
    logic       found;
    // Scan from last_grant+1 so the most recently served core has lowest priority.
    always_comb begin
        nxt_grant = last_grant;
        found = 1'b0;
        idx = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = 4'(last_grant) + 4'(k);
            idx = (idx >= 4'(NUM_CORES)) ? idx - 4'(NUM_CORES) : idx;
            if (!found && req[idx[IW-1:0]]) begin
                nxt_grant = idx[2:0];
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mem_addr <= '0;
            grant_id <= '0;
            last_grant <= 3'(NUM_CORES - 1);
        end else begin
            case (state)
                IDLE: if (found) begin
                    state <= ISSUE;
                    grant_id <= nxt_grant;
                    mem_addr <= core_addr[{nxt_grant[IW-1:0], 5'b0} +: 32];
                end
                ISSUE: state <= WAIT;
                WAIT: if (updated) state <= DONE;
                default: begin
                    state <= IDLE;
                    last_grant <= grant_id;
                end
            endcase
        end
    end
    assign trace_ready = state == ISSUE;
    assign busy = state != IDLE;
    assign ack = (state == DONE) ? NUM_CORES'(1) << grant_id : '0;
`ifdef TRACE_ARB_STATS_EN
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_cnt
        logic [CNT_W-1:0] hit, miss;
        always_ff @(posedge clk) begin
            if (rst) begin
                hit <= '0;
                miss <= '0;
            end else if (state == WAIT && updated && grant_id == 3'(i)) begin
                if (found_in_cache) hit <= hit + CNT_W'(~&hit);
                else miss <= miss + CNT_W'(~&miss);
            end
        end
        assign core_hit_count[i*CNT_W +: CNT_W] = hit;
        assign core_miss_count[i*CNT_W +: CNT_W] = miss;
    end
`else
    logic unused_stats;
    assign unused_stats = found_in_cache;
    assign core_hit_count = '0;
    assign core_miss_count = '0;
`endif
endmodule
